// File: rtl/reg_alu_datapath.sv
// Register file plus two-stage ALU pipeline (READ latches operands, EXEC computes the result).
// A side-band load port can preload registers; loads win over write-back on the same address.
module reg_alu_datapath #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    input  logic             rd,
    input  logic [2:0]       alu_ctrl,
    input  logic [AW-1:0]    wr_addr,
    input  logic             wr,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic [WIDTH-1:0] result,
    output logic             res_valid,
    output logic             cy,
    output logic             zero
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_rd_data1, r_rd_data2, r_result;
    logic [2:0]       r_op;
    logic             r_exec_pend, r_res_valid, r_cy, r_zero;

    logic             w_wr_eff;
    logic [WIDTH-1:0] w_op_a, w_op_b, w_alu_res;
    logic             w_alu_cy;

    // Strobes are single-cycle and unconditionally accepted; there is no back-pressure.
    assign w_wr_eff = wr && !(ld_en && (ld_addr == wr_addr));

    // Operand reads see the value being written on the same edge.
    always_comb begin
        w_op_a = r_regs[addr1];
        if (ld_en && (ld_addr == addr1))
            w_op_a = ld_data;
        else if (w_wr_eff && (wr_addr == addr1))
            w_op_a = r_result;
        w_op_b = r_regs[addr2];
        if (ld_en && (ld_addr == addr2))
            w_op_b = ld_data;
        else if (w_wr_eff && (wr_addr == addr2))
            w_op_b = r_result;
    end

    always_comb begin
        w_alu_res = '0;
        w_alu_cy  = 1'b0;
        case (r_op)
            3'b000: {w_alu_cy, w_alu_res} = {1'b0, r_rd_data1} + {1'b0, r_rd_data2};
            3'b001: {w_alu_cy, w_alu_res} = {1'b0, r_rd_data1} - {1'b0, r_rd_data2};
            3'b010: w_alu_res = r_rd_data1 & r_rd_data2;
            3'b011: w_alu_res = r_rd_data1 | r_rd_data2;
            3'b100: w_alu_res = r_rd_data1 ^ r_rd_data2;
            3'b101: w_alu_res = ~r_rd_data1;
            3'b110: {w_alu_cy, w_alu_res} = {r_rd_data1, 1'b0};
            default: w_alu_res = r_rd_data2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else begin
            if (w_wr_eff)
                r_regs[wr_addr] <= r_result;
            if (ld_en)
                r_regs[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data1  <= '0;
            r_rd_data2  <= '0;
            r_op        <= '0;
            r_exec_pend <= 1'b0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_cy        <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            if (rd) begin
                r_rd_data1 <= w_op_a;
                r_rd_data2 <= w_op_b;
                r_op       <= alu_ctrl;
            end
            r_exec_pend <= rd;
            // A result computed on this edge is newer than the one being written back.
            if (r_exec_pend) begin
                r_result    <= w_alu_res;
                r_cy        <= w_alu_cy;
                r_zero      <= (w_alu_res == '0);
                r_res_valid <= 1'b1;
            end else if (wr) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign rd_data1  = r_rd_data1;
    assign rd_data2  = r_rd_data2;
    assign result    = r_result;
    assign res_valid = r_res_valid;
    assign cy        = r_cy;
    assign zero      = r_zero;
endmodule

// File: doc/reg_alu_datapath.md
# reg_alu_datapath

- Responder side of the control-unit interface.
- Holds the 8-entry register file and the ALU.
- Serves the `addr1`/`addr2`/`rd` operand reads and the `wr_addr`/`wr` write-back.
- Executes the operation selected by `alu_ctrl` and returns the `cy` and `zero` flags.
- A side-band load port lets the bench or a loader preload registers before execution starts.

## Interface
Parameters:
- `WIDTH`, 16, data width of registers, operands and result
- `AW`, 3, register address width (2**AW entries)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `addr1`  in  AW  operand A register address
- `addr2`  in  AW  operand B register address
- `rd`  in  1  operand read strobe
- `alu_ctrl`  in  3  ALU operation select, sampled with `rd`
- `wr_addr`  in  AW  write-back register address
- `wr`  in  1  write-back strobe, writes the result register
- `ld_en`  in  1  side-band load strobe
- `ld_addr`  in  AW  load address
- `ld_data`  in  WIDTH  load data
- `rd_data1`  out  WIDTH  latched operand A
- `rd_data2`  out  WIDTH  latched operand B
- `result`  out  WIDTH  registered ALU result
- `res_valid`  out  1  result register holds a value computed since its last write-back
- `cy`  out  1  carry/borrow flag
- `zero`  out  1  result-equals-zero flag

Reset: one clock; reset is asynchronous and active-low. On `rst_n` low, all of the following clear immediately:
- all registers, `rd_data1`, `rd_data2`, `result`
- `res_valid`, `cy`, `zero`

## Operation
Two-stage pipeline: READ, then EXEC.

READ (edge where `rd`=1):
- `rd_data1` <= reg[`addr1`] and `rd_data2` <= reg[`addr2`].
- The pending op latches from `alu_ctrl`.
- An internal `exec_pend` flag is set.

EXEC (edge after `exec_pend`=1):
- `result` <= f(`rd_data1`, `rd_data2`).
- `cy` and `zero` update.
- `res_valid` <= 1 and `exec_pend` <= 0.

WRITE (edge where `wr`=1):
- reg[`wr_addr`] <= `result` as held before that edge.
- `res_valid` <= 0.
- `wr` with `res_valid`=0 still writes; `res_valid` is informational only.

ALU ops (A=`rd_data1`, B=`rd_data2`):
- 000 A+B; `cy` = carry out of bit WIDTH-1
- 001 A−B; `cy` = borrow (1 when A < B unsigned)
- 010 A&B
- 011 A|B
- 100 A^B
- 101 ~A
- 110 A<<1; `cy` = A[WIDTH-1]
- 111 pass B
- Ops 010–101 and 111 clear `cy`.
- `zero` = (result == 0) for every op.
- All arithmetic is modulo 2**WIDTH.

Load: on an edge with `ld_en`=1, reg[`ld_addr`] <= `ld_data`.

Conflict rules:
- `ld_en` and `wr` to the same address on the same edge: `ld_en` wins and `wr` is dropped, but `res_valid` still clears.
- `ld_en` and `wr` to different addresses: both write.
- Read bypass: `rd` on the same edge as a write (`wr` or `ld_en`) to `addr1`/`addr2` latches the new write value, not the old register content.
- `rd` on the same edge as EXEC: EXEC uses the previous operands; new operands latch for the next EXEC. Back-to-back `rd` every cycle gives one result per cycle.
- `wr` on the same edge as EXEC: writes the old `result`; the new `result` lands after.

Register 0 is an ordinary register (not hardwired).

## Timing
- `rd` at edge N: `rd_data1`/`rd_data2` are valid after N.
- `result`, `cy`, `zero`, `res_valid` are valid after N+1.
- Earliest useful `wr` is at edge N+2, which commits at N+2; a `rd` at N+2 to that address sees the value through the bypass.
- Flags hold their value until the next EXEC; `wr`, `ld_en` and idle cycles do not change them.
- Reset mid-operation: all state clears asynchronously and `exec_pend` clears. No EXEC occurs at the first edge after `rst_n` rises, even if `rd` was high before reset.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle → all outputs 0 immediately; read all 8 registers after release → 0.
- Add with carry: load r1=0xFFFF and r2=0x0001; `rd` addr1=1, addr2=2, op 000; `wr` r3 two cycles later → `result`=0x0000, `cy`=1, `zero`=1; a later read of r3 gives 0x0000.
- Subtract with borrow: r1=0x0003, r2=0x0005, op 001 → `result`=0xFFFE, `cy`=1, `zero`=0; swapping operands → 0x0002, `cy`=0.
- Bypass and conflict:
  - `wr` r4 with `result`=0x1234 on the same edge as `rd` addr1=4 → `rd_data1`=0x1234.
  - `ld_en` r4=0xAAAA on the same edge as `wr` r4 → r4=0xAAAA and `res_valid`=0.
- Back-to-back pipeline: `rd` each cycle with ops 010, 011, 100 on r1=0x0F0F, r2=0x00FF → `result` sequence 0x000F, 0x0FFF, 0x0FF0 on consecutive cycles, `cy`=0 throughout.
- Shift and flags hold: r1=0x8001, op 110 → `result`=0x0002, `cy`=1; then 3 idle cycles plus a `wr` → `cy`=1 and `zero`=0 remain unchanged.
